// File: rtl/mul_seq_if.sv
// mul_seq_if: operand/result handshake bundle for the mul_seq iterative multiplier.
// The acc signal exists only when MUL_SEQ_ACC_EN is defined.
interface mul_seq_if #(
  parameter int N_BIT = 4
);
  localparam int RES_SIZE = 2 * N_BIT;

  logic                in_valid;
  logic                in_ready;
  logic [N_BIT-1:0]    A;
  logic [N_BIT-1:0]    B;
  logic                mul_type;
`ifdef MUL_SEQ_ACC_EN
  logic                acc;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [RES_SIZE-1:0] product;
  logic                busy;

  // Producer/consumer side (drives operands, takes the product)
  modport master (
    output in_valid, A, B, mul_type,
`ifdef MUL_SEQ_ACC_EN
    output acc,
`endif
    output out_ready,
    input  in_ready, out_valid, product, busy
  );

  // Multiplier side
  modport slave (
    input  in_valid, A, B, mul_type,
`ifdef MUL_SEQ_ACC_EN
    input  acc,
`endif
    input  out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier, one multiplier bit per cycle (LSB first),
// unsigned or two's-complement signed, with valid/ready handshakes on both sides.
// Optional compile-time feature: MUL_SEQ_ACC_EN adds an accumulate request (bus.acc)
// that seeds the partial-product accumulator with the previous product.
module mul_seq #(
  parameter int N_BIT = 4
) (
  input logic     clk,
  input logic     rst,
  mul_seq_if.slave bus
);
  localparam int RES_SIZE = 2 * N_BIT;
  localparam int CW       = $clog2(N_BIT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [N_BIT-1:0]    b_reg;
  logic                type_reg;
  logic [RES_SIZE-1:0] a_ext;
  logic [RES_SIZE-1:0] accum;
  logic [RES_SIZE-1:0] addend;
  logic [RES_SIZE-1:0] accum_nxt;
  logic [RES_SIZE-1:0] product_q;
  logic                in_ready_c;
  logic                out_valid_c;
  logic                busy_c;
  logic                accept;
  logic                last;

  assign accept = bus.in_valid && in_ready_c;
  assign last   = (cnt == CW'(N_BIT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE: begin
        busy_c     = 1'b0;
        in_ready_c = !rst;
        if (bus.in_valid && !rst) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add step; the sign bit's weight is negative for signed operands,
  // so the final step subtracts instead of adding.
  always_comb begin
    addend    = b_reg[cnt] ? (a_ext << cnt) : '0;
    accum_nxt = (type_reg && last) ? (accum - addend) : (accum + addend);
  end

  // Operand capture, accumulation and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      b_reg     <= '0;
      type_reg  <= 1'b0;
      a_ext     <= '0;
      accum     <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_ext    <= bus.mul_type ? {{N_BIT{bus.A[N_BIT-1]}}, bus.A}
                                     : {{N_BIT{1'b0}}, bus.A};
            b_reg    <= bus.B;
            type_reg <= bus.mul_type;
            cnt      <= '0;
`ifdef MUL_SEQ_ACC_EN
            accum    <= bus.acc ? product_q : '0;
`else
            accum    <= '0;
`endif
          end
        end
        RUN: begin
          accum <= accum_nxt;
          cnt   <= cnt + 1'b1;
          if (last) product_q <= accum_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.product   = product_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: randomized self-checking bench for mul_seq (N_BIT = 4) against an
// arithmetic reference model. Define MUL_SEQ_ACC_EN to also exercise accumulate mode.
module tb_mul_seq;
  localparam int N   = 4;
  localparam int RES = 2 * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_seq_if #(.N_BIT(N)) bus ();
  mul_seq #(.N_BIT(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int             n_checks   = 0;
  int             n_fail     = 0;
  logic [RES-1:0] model_prev = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Product of the operands as plain integers, reduced mod 2^RES
  function automatic logic [RES-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic t);
    int x, y;
    x = t ? int'($signed(a)) : int'(a);
    y = t ? int'($signed(b)) : int'(b);
    return RES'(x * y);
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_product", bus.product, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst        = 1'b0;
    model_prev = '0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
  endtask

  // One full transaction; called at a negedge. A/B/mul_type are scrambled while busy.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic t,
                       input logic ac, input int hold, input bit rand_ready);
    logic [RES-1:0] exp;
    int cnt;
    exp = (ac ? model_prev : RES'(0)) + model(a, b, t);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.mul_type = t;
`ifdef MUL_SEQ_ACC_EN
    bus.acc      = ac;
`endif
    cnt = 0;
    while (!bus.in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cnt = 1;
    while (!bus.out_valid && cnt < 30) begin
      check("run_busy", bus.busy, 1);
      check("run_in_ready", bus.in_ready, 0);
      bus.A        = N'($urandom);
      bus.B        = N'($urandom);
      bus.mul_type = 1'($urandom);
`ifdef MUL_SEQ_ACC_EN
      bus.acc      = 1'($urandom);
`endif
      if (rand_ready) bus.out_ready = 1'($urandom);
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, N + 1);
    check("product", bus.product, exp);
    bus.out_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_product", bus.product, exp);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("done_valid_clear", bus.out_valid, 0);
    check("next_in_ready", bus.in_ready, 1);
    check("idle_product_kept", bus.product, exp);
    model_prev = exp;
  endtask

  initial begin
    int cnt;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.mul_type  = 1'b0;
`ifdef MUL_SEQ_ACC_EN
    bus.acc       = 1'b0;
`endif
    do_reset();

    // Corner products
    do_op(4'hF, 4'hF, 1'b0, 1'b0, 0, 0);
    check("umax", bus.product, 8'hE1);
    do_op(4'h8, 4'h8, 1'b1, 1'b0, 1, 0);
    check("smin_sq", bus.product, 8'h40);
    do_op(4'h8, 4'h7, 1'b1, 1'b0, 0, 0);
    check("smin_x_smax", bus.product, 8'hC8);
    do_op(4'hF, 4'hF, 1'b1, 1'b0, 2, 0);
    check("sneg1_sq", bus.product, 8'h01);

    // Backpressure with operands scrambled during RUN
    do_op(4'h3, 4'h5, 1'b0, 1'b0, 10, 0);
    check("backpressure", bus.product, 8'h0F);

    // Reset on the second RUN cycle aborts the operation
    bus.in_valid = 1'b1;
    bus.A        = 4'h7;
    bus.B        = 4'h6;
    bus.mul_type = 1'b0;
`ifdef MUL_SEQ_ACC_EN
    bus.acc      = 1'b0;
`endif
    cnt = 0;
    while (!bus.in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_in_ready_wait", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_product", bus.product, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready_rst", bus.in_ready, 0);
    rst        = 1'b0;
    model_prev = '0;
    @(negedge clk);
    check("abort_in_ready", bus.in_ready, 1);
    repeat (10) begin
      @(negedge clk);
      check("abort_no_stale", bus.out_valid, 0);
      check("abort_idle", bus.busy, 0);
    end

    // Exhaustive sweep with random consumer backpressure
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          do_op(a[N-1:0], b[N-1:0], t[0], 1'b0, int'($urandom_range(0, 2)), 1);

`ifdef MUL_SEQ_ACC_EN
    // Accumulate: 3*4 plain, then (-2)*3 signed added on top
    do_reset();
    do_op(4'h3, 4'h4, 1'b0, 1'b0, 0, 0);
    check("acc_plain", bus.product, 8'h0C);
    do_op(4'hE, 4'h3, 1'b1, 1'b1, 0, 0);
    check("acc_signed", bus.product, 8'h06);
    for (int i = 0; i < 40; i++)
      do_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_seq.md
# mul_seq

Parametrised iterative multiplier with valid/ready handshakes and a registered result. It computes one unsigned or two's-complement signed N_BIT×N_BIT product over N_BIT clock cycles. It sits in the execute stage beside the ALU as the area-reduced, multi-cycle successor to the single-cycle combinational array multiplier. An optional accumulate mode is available at compile time.

## Interface
- N_BIT, 4: operand width; legal range 2–32.
- RES_SIZE, 2*N_BIT: product width; fixed at 2*N_BIT and never overridden.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands and mode are presented.
- in_ready  out  1  block can accept an operation (IDLE only).
- A  in  N_BIT  multiplicand.
- B  in  N_BIT  multiplier.
- mul_type  in  1  0 = unsigned × unsigned; 1 = signed × signed (two's complement).
- acc  in  1  accumulate request; present only with MUL_SEQ_ACC_EN.
- out_valid  out  1  product is valid.
- out_ready  in  1  consumer takes the product.
- product  out  RES_SIZE  result register.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- in_ready = (state == IDLE) && !rst.
- busy = (state != IDLE).
- out_valid = (state == DONE).
- IDLE: on in_valid && in_ready, the block does the following, then goes to RUN:
  - registers A, B and mul_type (and acc when compiled in);
  - clears the partial-product accumulator;
  - sets the bit counter to 0.
- RUN: retires one multiplier bit per cycle, LSB first, for N_BIT cycles.
  - Unsigned: add (B[i] ? A zero-extended : 0) << i.
  - Signed: add (B[i] ? A sign-extended : 0) << i for i < N_BIT-1, and subtract it for i = N_BIT-1.
  - All arithmetic is mod 2^RES_SIZE.
  - After the step with counter == N_BIT-1, go to DONE and load product.
- DONE: product and out_valid are held stable until out_valid && out_ready. Then go to IDLE.
- Result: product = A×B interpreted per mul_type, mod 2^RES_SIZE. Every legal case fits exactly, including signed (−2^(N-1))².
- Input changes on A, B, mul_type and acc while busy are ignored.
- in_valid while busy is not accepted; the producer must hold it.
- product keeps its last value in IDLE; it is not cleared on accept.

## Timing
- Reset values:
  - state = IDLE;
  - product = 0;
  - out_valid = 0;
  - busy = 0;
  - counter = 0;
  - in_ready = 0 while rst is high, 1 in the first cycle after rst is released.
- Reset asserted in RUN or DONE aborts the operation. The next state is IDLE with product = 0, and no out_valid pulse is issued.
- Latency: accept edge at cycle T → out_valid high from cycle T+N_BIT+1, i.e. N_BIT RUN cycles plus the DONE register.
- Handshake completes on the same edge where out_valid && out_ready. in_ready is high the following cycle.
- Best-case throughput: one operation every N_BIT+2 cycles.
- There is no same-cycle accept-while-DONE path.
- out_ready high before out_valid has no effect.

## Configuration
- MUL_SEQ_ACC_EN defined:
  - port acc exists and is sampled at accept;
  - acc = 1: the partial-product accumulator is initialised with the current product instead of 0, so the result is product_prev + A×B mod 2^RES_SIZE;
  - the sign of the addend follows mul_type;
  - acc = 0: behaves as a plain multiply;
  - rst clears the accumulated value.
- MUL_SEQ_ACC_EN undefined: port acc is absent and every operation is a plain multiply. Timing is identical in both builds.

## Test plan
All scenarios use N_BIT = 4.
- Unsigned max: A=0xF, B=0xF, mul_type=0 → out_valid exactly 5 cycles after the accept edge; product = 0xE1.
- Signed corners:
  - A=0x8, B=0x8, mul_type=1 → product = 0x40;
  - A=0x8, B=0x7 → 0xC8;
  - A=0xF, B=0xF → 0x01.
- Backpressure: out_ready held low 10 cycles after out_valid → product and out_valid are stable throughout; in_ready = 0; A and B toggled during RUN do not alter the result (A=3, B=5 → 0x0F).
- Reset mid-RUN: rst high on the 2nd RUN cycle → the next cycle shows state IDLE, product = 0, out_valid = 0; no stale result appears afterwards.
- Exhaustive sweep: all 256 A/B pairs × both mul_type values, random out_ready → each product matches the reference model, one result per accept, none lost or duplicated.
- MUL_SEQ_ACC_EN: reset, then 3×4 with acc=0, then signed (−2)×3 with acc=1 → products 0x0C, then 0x06.
